// File: rtl/tap_tempo.sv
// Tap-tempo input stage.
// A bouncy active-low push-button is synchronised and debounced. The block
// then measures the clock-cycle interval between consecutive presses, and a
// restoring divider turns that interval into beats per minute:
// bpm = floor(60*CLK_HZ / N), clamped to [BPM_MIN, BPM_MAX].
module tap_tempo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int BPM_MIN      = 30,
  parameter int BPM_MAX      = 300,
  parameter int DEFAULT_BPM  = 60,
  parameter int BPM_W        = 9,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tap_n,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             armed,
  output logic             busy
);

  // Derived constants. They are computed in 64 bits because 60*CLK_HZ
  // overflows a signed 32-bit int at the default clock rate.
  localparam logic [63:0]      K_WIDE  = 64'd60 * 64'(CLK_HZ);
  localparam logic [CNT_W-1:0] K       = CNT_W'(K_WIDE);
  localparam logic [CNT_W-1:0] MIN_INT = CNT_W'(K_WIDE / 64'(BPM_MAX));
  localparam logic [CNT_W-1:0] MAX_INT = CNT_W'(K_WIDE / 64'(BPM_MIN));

  localparam logic [CNT_W-1:0] BPM_MIN_C   = CNT_W'(BPM_MIN);
  localparam logic [CNT_W-1:0] BPM_MAX_C   = CNT_W'(BPM_MAX);
  localparam logic [BPM_W-1:0] BPM_DEFAULT = BPM_W'(DEFAULT_BPM);

  localparam int               DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  localparam int                STEP_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DIVIDE = 2'd2
  } state_t;

  // Input conditioning.
  logic            sync_q1;
  logic            sync_q2;
  logic            db;
  logic [DB_W-1:0] db_cnt;
  logic            tap;

  // Control.
  state_t          state;
  state_t          state_next;
  logic [CNT_W-1:0] int_cnt;
  logic            int_ok;
  logic            int_timeout;
  logic            capture;

  // Divider datapath.
  logic [CNT_W-1:0]  div_den;
  logic [CNT_W-1:0]  div_quo;
  logic [CNT_W-1:0]  div_rem;
  logic [STEP_W-1:0] div_step;
  logic              div_last;
  logic [CNT_W:0]    rem_shift;
  logic              rem_ge;
  logic [CNT_W-1:0]  rem_sub;
  logic [CNT_W-1:0]  rem_next;
  logic [CNT_W-1:0]  quo_next;
  logic [CNT_W-1:0]  q_clamped;

  // Two-flop synchroniser; both stages idle high (button released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make sync_q2 take the old sync_q1,
      // which is what builds the two-stage chain; blocking would merge them.
      sync_q1 <= tap_n;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYC differing cycles,
  // and pulse tap for one cycle on an accepted press (1 -> 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= 1'b1;
      db_cnt <= '0;
      tap    <= 1'b0;
    end else begin
      tap <= 1'b0;
      if (sync_q2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= sync_q2;
        db_cnt <= '0;
        tap    <= db;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Interval qualification against the accepted tempo window.
  always_comb begin
    // NOTE: every signal gets a value on every path through an always_comb;
    // a missing default here would infer a latch.
    int_ok      = (int_cnt >= MIN_INT) && (int_cnt <= MAX_INT);
    int_timeout = (int_cnt >= MAX_INT);
    capture     = (state == S_ARMED) && tap && int_ok;
    div_last    = (div_step == STEP_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (tap) state_next = S_ARMED;
      end
      S_ARMED: begin
        // A too-short interval simply restarts timing from this tap.
        if (capture)          state_next = S_DIVIDE;
        else if (!tap && int_timeout) state_next = S_IDLE;
      end
      S_DIVIDE: begin
        if (div_last) state_next = S_ARMED;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    armed = 1'b0;
    busy  = 1'b0;
    unique case (state)
      S_ARMED:  armed = 1'b1;
      S_DIVIDE: begin
        armed = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Interval counter: restarts at 1 on every tap so that the value seen on
  // the next tap equals the tap spacing; it keeps running through DIVIDE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt <= '0;
    end else if (tap) begin
      int_cnt <= CNT_W'(1);
    end else if (state_next == S_IDLE) begin
      int_cnt <= '0;
    end else begin
      int_cnt <= int_cnt + 1'b1;
    end
  end

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor when it fits.
  always_comb begin
    rem_shift = {div_rem, div_quo[CNT_W-1]};
    rem_ge    = (rem_shift >= {1'b0, div_den});
    rem_sub   = rem_shift[CNT_W-1:0] - div_den;
    rem_next  = rem_ge ? rem_sub : rem_shift[CNT_W-1:0];
    quo_next  = {div_quo[CNT_W-2:0], rem_ge};
  end

  // Clamp the finished quotient into the displayable tempo range.
  always_comb begin
    q_clamped = quo_next;
    if (quo_next < BPM_MIN_C) begin
      q_clamped = BPM_MIN_C;
    end else if (quo_next > BPM_MAX_C) begin
      q_clamped = BPM_MAX_C;
    end
  end

  // Divider registers: load on an accepted interval, then one bit per cycle.
  // The quotient register starts as the dividend K and fills with result
  // bits from the bottom as the dividend bits shift out of the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset along with control so that a
      // reset mid-division leaves nothing stale behind; they are plain flops,
      // not a memory array, so the reset costs nothing in inference.
      div_den  <= '0;
      div_quo  <= '0;
      div_rem  <= '0;
      div_step <= '0;
    end else if (capture) begin
      div_den  <= int_cnt;
      div_quo  <= K;
      div_rem  <= '0;
      div_step <= '0;
    end else if (state == S_DIVIDE) begin
      div_rem  <= rem_next;
      div_quo  <= quo_next;
      div_step <= div_step + 1'b1;
    end
  end

  // Result register: publish the clamped quotient with a one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpm       <= BPM_DEFAULT;
      bpm_valid <= 1'b0;
    end else begin
      bpm_valid <= 1'b0;
      if ((state == S_DIVIDE) && div_last) begin
        bpm       <= BPM_W'(q_clamped);
        bpm_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tap_tempo.sv
// Self-checking bench for tap_tempo with a small clock so intervals are short:
// K = 60000, MIN_INT = 200, MAX_INT = 2000, press-to-tap latency 66 cycles.
module tb_tap_tempo;

  localparam int CLK_HZ       = 1000;
  localparam int DEBOUNCE_CYC = 64;
  localparam int BPM_MIN      = 30;
  localparam int BPM_MAX      = 300;
  localparam int DEFAULT_BPM  = 60;
  localparam int BPM_W        = 9;
  localparam int CNT_W        = 32;

  localparam int K       = 60 * CLK_HZ;
  localparam int MIN_INT = K / BPM_MAX;
  localparam int MAX_INT = K / BPM_MIN;
  localparam int TAP_LAT = 2 + DEBOUNCE_CYC;
  localparam int DIV_LAT = CNT_W + 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             tap_n = 1'b1;
  logic [BPM_W-1:0] bpm;
  logic             bpm_valid;
  logic             armed;
  logic             busy;

  tap_tempo #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .BPM_MIN     (BPM_MIN),
    .BPM_MAX     (BPM_MAX),
    .DEFAULT_BPM (DEFAULT_BPM),
    .BPM_W       (BPM_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tap_n    (tap_n),
    .bpm      (bpm),
    .bpm_valid(bpm_valid),
    .armed    (armed),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: the cycle after the k-th rising edge has cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Pulse monitor: record every bpm_valid cycle and value.
  int   obs_cyc[$];
  int   obs_bpm[$];
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bpm_valid === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_bpm.push_back(int'(bpm));
      check("valid_single_cycle", prev_valid, 0);
    end
    prev_valid = bpm_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic clear_obs();
    obs_cyc.delete();
    obs_bpm.delete();
  endtask

  // Clean press schedule (absolute fall cycle, low duration).
  int fall_q[$];
  int hold_q[$];

  task automatic clear_presses();
    fall_q.delete();
    hold_q.delete();
  endtask

  task automatic add_press(input int fall, input int hold);
    fall_q.push_back(fall);
    hold_q.push_back(hold);
  endtask

  task automatic play_presses();
    for (int i = 0; i < fall_q.size(); i++) begin
      wait_cycle(fall_q[i]);
      tap_n = 1'b0;
      wait_cycle(fall_q[i] + hold_q[i]);
      tap_n = 1'b1;
    end
  endtask

  // Reference model: from press times alone, predict each tempo update.
  // A tap arms an idle block; a tap within MAX_INT of the previous one
  // measures an interval, which updates bpm DIV_LAT cycles later when it is
  // at least MIN_INT; more than MAX_INT of silence returns to idle.
  int exp_cyc[$];
  int exp_bpm[$];
  int exp_now = DEFAULT_BPM;

  task automatic model_presses();
    bit m_armed = 1'b0;
    int m_last  = 0;
    exp_cyc.delete();
    exp_bpm.delete();
    foreach (fall_q[i]) begin
      int t;
      t = fall_q[i] + TAP_LAT;
      if (m_armed && (t - m_last > MAX_INT)) m_armed = 1'b0;
      if (!m_armed) begin
        m_armed = 1'b1;
        m_last  = t;
      end else begin
        int n;
        int q;
        n      = t - m_last;
        m_last = t;
        if (n >= MIN_INT) begin
          q = K / n;
          if (q < BPM_MIN) q = BPM_MIN;
          if (q > BPM_MAX) q = BPM_MAX;
          exp_cyc.push_back(t + DIV_LAT);
          exp_bpm.push_back(q);
          exp_now = q;
        end
      end
    end
  endtask

  task automatic compare_pulses(input string tag);
    int n;
    check({tag, "_pulse_count"}, obs_cyc.size(), exp_cyc.size());
    n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_pulse_cycle"}, obs_cyc[i], exp_cyc[i]);
      check({tag, "_pulse_bpm"}, obs_bpm[i], exp_bpm[i]);
    end
    check({tag, "_bpm_held"}, bpm, exp_now);
  endtask

  // Wait until the block must have timed out after the last press.
  task automatic settle(input int last_fall);
    wait_cycle(last_fall + TAP_LAT + MAX_INT + 10);
    check("settle_idle", armed, 0);
  endtask

  // Press with 20-cycle bounce bursts on both the press and the release.
  task automatic bounce_press(input int start);
    wait_cycle(start);
    for (int i = 0; i < 20; i++) begin
      tap_n = 1'((i % 2) != 0);
      tick(1);
    end
    tap_n = 1'b0;
    tick(150);
    for (int i = 0; i < 20; i++) begin
      tap_n = 1'((i % 2) == 0);
      tick(1);
    end
    tap_n = 1'b1;
  endtask

  typedef struct {
    int gap;
    int n_pulse;
    int exp_bpm;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   base;
    int   t2;
    int   bad;
    int   t;

    // Two presses from idle: spacing -> expected pulses and tempo.
    vecs[0] = '{gap: 500,  n_pulse: 1, exp_bpm: 120};
    vecs[1] = '{gap: 700,  n_pulse: 1, exp_bpm: 85};
    vecs[2] = '{gap: 199,  n_pulse: 0, exp_bpm: 0};
    vecs[3] = '{gap: 200,  n_pulse: 1, exp_bpm: 300};
    vecs[4] = '{gap: 2000, n_pulse: 1, exp_bpm: 30};
    vecs[5] = '{gap: 600,  n_pulse: 1, exp_bpm: 100};
    vecs[6] = '{gap: 2001, n_pulse: 0, exp_bpm: 0};
    vecs[7] = '{gap: 1500, n_pulse: 1, exp_bpm: 40};

    // Reset and long idle.
    rst_n = 1'b0;
    tap_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("reset_bpm", bpm, DEFAULT_BPM);
    check("reset_valid", bpm_valid, 0);
    check("reset_armed", armed, 0);
    check("reset_busy", busy, 0);
    bad = 0;
    repeat (5000) begin
      tick(1);
      if (bpm !== BPM_W'(DEFAULT_BPM) || bpm_valid !== 1'b0 || armed !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    check("idle_5000_cycles", bad, 0);

    // Chain 500 then 700 with exact divide timing on the first interval.
    clear_obs();
    clear_presses();
    base = cyc + 5;
    add_press(base, 70);
    add_press(base + 500, 70);
    add_press(base + 1200, 70);
    t2 = base + 500 + TAP_LAT;
    fork
      play_presses();
      begin
        wait_cycle(t2);
        check("div_tap_cycle_busy", busy, 0);
        wait_cycle(t2 + 1);
        check("div_first_busy", busy, 1);
        check("div_first_armed", armed, 1);
        wait_cycle(t2 + CNT_W);
        check("div_last_busy", busy, 1);
        check("div_last_no_valid", bpm_valid, 0);
        wait_cycle(t2 + DIV_LAT);
        check("div_done_busy", busy, 0);
        check("div_done_valid", bpm_valid, 1);
        check("div_done_bpm", bpm, 120);
      end
    join
    model_presses();
    wait_cycle(base + 1200 + TAP_LAT + DIV_LAT + 5);
    compare_pulses("chain");
    check("chain_bpm_85", bpm, 85);
    settle(base + 1200);

    // Table of two-press intervals from idle.
    for (int v = 0; v < 8; v++) begin
      clear_obs();
      clear_presses();
      base = cyc + 5;
      add_press(base, 70);
      add_press(base + vecs[v].gap, 70);
      play_presses();
      wait_cycle(base + vecs[v].gap + TAP_LAT + DIV_LAT + 5);
      check("vec_pulse_count", obs_cyc.size(), vecs[v].n_pulse);
      if (vecs[v].n_pulse > 0) begin
        exp_now = vecs[v].exp_bpm;
        if (obs_cyc.size() > 0) begin
          check("vec_pulse_cycle", obs_cyc[0], base + vecs[v].gap + TAP_LAT + DIV_LAT);
          check("vec_pulse_bpm", obs_bpm[0], vecs[v].exp_bpm);
        end
      end
      check("vec_bpm_held", bpm, exp_now);
      settle(base + vecs[v].gap);
    end

    // Bouncy presses spaced 1000: one tap per press, tempo 60.
    clear_obs();
    base = cyc + 5;
    for (int p = 0; p < 3; p++) bounce_press(base + 1000 * p);
    wait_cycle(base + 2000 + 20 + TAP_LAT + DIV_LAT + 10);
    check("bounce_pulse_count", obs_cyc.size(), 2);
    if (obs_cyc.size() == 2) begin
      check("bounce_bpm_first", obs_bpm[0], 60);
      check("bounce_bpm_second", obs_bpm[1], 60);
      check("bounce_first_cycle", obs_cyc[0], base + 1000 + 20 + TAP_LAT + DIV_LAT);
      check("bounce_spacing", obs_cyc[1] - obs_cyc[0], 1000);
    end
    exp_now = 60;
    settle(base + 2000 + 20);

    // Boundary chain: 200 then 2000 gives 300 then 30.
    clear_obs();
    clear_presses();
    base = cyc + 5;
    add_press(base, 70);
    add_press(base + 200, 70);
    add_press(base + 2200, 70);
    model_presses();
    play_presses();
    wait_cycle(base + 2200 + TAP_LAT + DIV_LAT + 5);
    compare_pulses("boundary");
    check("boundary_bpm_30", bpm, 30);
    settle(base + 2200);

    // Single press then silence: exact timeout.
    clear_obs();
    clear_presses();
    base = cyc + 5;
    add_press(base, 70);
    t = base + TAP_LAT;
    fork
      play_presses();
      begin
        wait_cycle(t);
        check("timeout_tap_cycle_armed", armed, 0);
        wait_cycle(t + 1);
        check("timeout_armed_after_tap", armed, 1);
      end
    join
    wait_cycle(t + MAX_INT);
    check("timeout_still_armed", armed, 1);
    wait_cycle(t + MAX_INT + 1);
    check("timeout_armed_drop", armed, 0);
    check("timeout_no_pulse", obs_cyc.size(), 0);
    check("timeout_bpm_held", bpm, exp_now);

    // Following pair 600 apart gives 100.
    clear_obs();
    clear_presses();
    base = cyc + 5;
    add_press(base, 70);
    add_press(base + 600, 70);
    model_presses();
    play_presses();
    wait_cycle(base + 600 + TAP_LAT + DIV_LAT + 5);
    compare_pulses("after_timeout");
    check("after_timeout_bpm_100", bpm, 100);
    settle(base + 600);

    // A 40-cycle glitch is shorter than the debounce window.
    clear_obs();
    base = cyc + 5;
    wait_cycle(base);
    tap_n = 1'b0;
    wait_cycle(base + 40);
    tap_n = 1'b1;
    bad = 0;
    repeat (300) begin
      tick(1);
      if (armed !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("glitch_no_state_change", bad, 0);
    check("glitch_no_pulse", obs_cyc.size(), 0);
    check("glitch_bpm_held", bpm, exp_now);

    // Reset during a division aborts it and restores the default tempo.
    clear_obs();
    clear_presses();
    base = cyc + 5;
    add_press(base, 70);
    add_press(base + 500, 70);
    play_presses();
    t2 = base + 500 + TAP_LAT;
    wait_cycle(t2 + 10);
    check("abort_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    tick(2);
    check("abort_bpm_in_reset", bpm, DEFAULT_BPM);
    rst_n = 1'b1;
    exp_now = DEFAULT_BPM;
    bad = 0;
    repeat (100) begin
      tick(1);
      if (busy !== 1'b0 || armed !== 1'b0) bad++;
    end
    check("abort_idle_after_reset", bad, 0);
    check("abort_no_pulse", obs_cyc.size(), 0);
    check("abort_bpm_default", bpm, DEFAULT_BPM);

    // Randomised press trains checked against the reference model.
    clear_obs();
    clear_presses();
    t = cyc + 5;
    for (int i = 0; i < 12; i++) begin
      int gap;
      int hmax;
      gap  = int'($urandom_range(2300, 150));
      hmax = (gap - 70 < 200) ? gap - 70 : 200;
      add_press(t, (i == 11) ? 70 : int'($urandom_range(hmax, 66)));
      if (i != 11) t += gap;
    end
    model_presses();
    play_presses();
    wait_cycle(t + TAP_LAT + DIV_LAT + 5);
    compare_pulses("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if something blocks indefinitely.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
